quant_scheduler: RTL and testbench
==================================

QUANT_SCHEDULER -- requirements
Module: quant_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one dynamic_quantization instance.
REQ-002 Parameter ID_W, default 2, width of the requester index ($clog2(NUM_REQ)).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_data  input  NUM_REQ*32  operand; requester i occupies bits [32i+31:32i].
REQ-008 req_in_prec  input  NUM_REQ*16  input precision code; requester i occupies [16i+15:16i].
REQ-009 req_out_prec  input  NUM_REQ*16  output precision code, same packing as req_in_prec.
REQ-010 q_data_in  output  32  operand to the quantizer.
REQ-011 q_in_prec  output  16  input precision code to the quantizer.
REQ-012 q_out_prec  output  16  output precision code to the quantizer.
REQ-013 q_data_out  input  32  quantizer result; one registered cycle after the q_* inputs are sampled.
REQ-014 resp_valid  output  1  result available.
REQ-015 resp_ready  input  1  consumer accepts the result.
REQ-016 resp_id  output  ID_W  index of the requester that owns the result.
REQ-017 resp_data  output  32  result word.
REQ-018 resp_err  output  1  high when the request carried an illegal precision code.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 Legal precision codes: 16'h0001 = 32-bit, 16'h0002 = 16-bit, 16'h0004 = 8-bit; any other value is illegal.
REQ-021 The FSM has four states: IDLE, ISSUE, CAPT, RESP.
REQ-022 IDLE: req_ready is driven combinationally high for exactly one requester, the granted one, and only when its req_valid is high.
REQ-023 Grant is round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so index 0 has first priority.
REQ-024 Handshake occurs when req_valid[g] & req_ready[g] are both high at a clock edge; the scheduler then registers operand, codes and g, and moves IDLE->ISSUE.
REQ-025 A requester holds valid and payload stable until ready; req_valid deasserted before a grant produces no transaction.
REQ-026 ISSUE: q_* outputs present the latched request for one cycle; always ->CAPT.
REQ-027 CAPT: q_data_out is registered into resp_data, or forced to 0 when either code is illegal, in which case resp_err=1; always ->RESP.
REQ-028 RESP: resp_valid=1 with resp_id/resp_data/resp_err stable until resp_ready=1; on that edge ->IDLE and last_grant<=resp_id.
REQ-029 Timing: resp_valid rises 3 edges after the accept edge; minimum spacing between successive accepts is 4 cycles.
REQ-030 req_ready is 0 outside IDLE; resp_ready is ignored outside RESP.
REQ-031 q_* outputs are registered and hold their last value when not in ISSUE.
REQ-032 A request whose requester drops req_valid while in ISSUE, CAPT or RESP still completes normally.

Reset
REQ-033 While rst=0, asynchronously: state=IDLE, q_*=0, resp_valid=0, resp_data=0, resp_err=0, resp_id=0, busy=0, last_grant=NUM_REQ-1.
REQ-034 Reset during ISSUE, CAPT or RESP discards the in-flight transaction; no response is produced after reset release.

Structure
REQ-035 Shared header quant_pkg holds the PREC_32/PREC_16/PREC_8 codes, the FSM state encodings and the NUM_REQ default.
REQ-036 Round-robin selection lives in one sub-module, rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index).

Verification
REQ-037 Reset release, req_valid=4'b0001, data 32'h1234_5678, codes 1/1, resp_ready=1 -> resp_valid 3 edges after accept, resp_id=0, resp_data=32'h1234_5678, resp_err=0.
REQ-038 req_valid=4'b1111 held, resp_ready=1 -> grants in order 0,1,2,3,0, each accept 4 cycles apart.
REQ-039 Request with in_prec=16'h0003 -> resp_err=1, resp_data=0, then next grant proceeds normally.
REQ-040 resp_ready held 0 for 5 cycles in RESP -> resp_* stable, req_ready=0, busy=1 throughout; release -> IDLE on the next edge.
REQ-041 rst pulled low mid-CAPT -> all outputs zero immediately, no resp_valid after release, first subsequent grant goes to index 0.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared constants for the quantizer scheduler: precision codes, FSM states,
// default requester count and the precision-code legality check.
`timescale 1ns/1ps
package quant_pkg;

  localparam logic [15:0] PREC_32 = 16'h0001;
  localparam logic [15:0] PREC_16 = 16'h0002;
  localparam logic [15:0] PREC_8  = 16'h0004;

  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic prec_legal(input logic [15:0] code);
    return (code == PREC_32) || (code == PREC_16) || (code == PREC_8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first active request at or after
// last_grant+1 (mod NUM_REQ); the grant is zero when nothing requests.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        grant        = '0;
        grant[cand]  = 1'b1;
        grant_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/quant_scheduler.sv
// Time-shares one dynamic_quantization instance between NUM_REQ requesters:
// round-robin accept, one-cycle issue, capture of the quantizer result, response.
`timescale 1ns/1ps
module quant_scheduler
  import quant_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*16-1:0] req_in_prec,
  input  logic [NUM_REQ*16-1:0] req_out_prec,
  output logic [31:0]           q_data_in,
  output logic [15:0]           q_in_prec,
  output logic [15:0]           q_out_prec,
  input  logic [31:0]           q_data_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  busy
);

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    id_latched;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               codes_bad;

  logic [31:0] data_arr     [NUM_REQ];
  logic [15:0] in_prec_arr  [NUM_REQ];
  logic [15:0] out_prec_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi]     = req_data[32*gi +: 32];
      assign in_prec_arr[gi]  = req_in_prec[16*gi +: 16];
      assign out_prec_arr[gi] = req_out_prec[16*gi +: 16];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Ready is only offered while idle, so an accept is exactly |grant in IDLE.
  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign busy      = (state != S_IDLE);

  // q_* double as the latched request, so they are checked in CAPT.
  assign codes_bad = !prec_legal(q_in_prec) || !prec_legal(q_out_prec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      id_latched <= '0;
      q_data_in  <= '0;
      q_in_prec  <= '0;
      q_out_prec <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            q_data_in  <= data_arr[grant_idx];
            q_in_prec  <= in_prec_arr[grant_idx];
            q_out_prec <= out_prec_arr[grant_idx];
            id_latched <= grant_idx;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_CAPT;
        S_CAPT: begin
          resp_data  <= codes_bad ? 32'd0 : q_data_out;
          resp_err   <= codes_bad;
          resp_id    <= id_latched;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= resp_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quant_scheduler.sv
// Directed bench for quant_scheduler with a one-cycle registered quantizer model
// that masks the operand to the requested output width.
`timescale 1ns/1ps
module tb_quant_scheduler;
  import quant_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_data = '0;
  logic [N*16-1:0] req_in_prec = '0;
  logic [N*16-1:0] req_out_prec = '0;
  logic [31:0]     q_data_in;
  logic [15:0]     q_in_prec;
  logic [15:0]     q_out_prec;
  logic [31:0]     q_data_out = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic            busy;

  always #5 clk = ~clk;

  quant_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_in_prec  (req_in_prec),
    .req_out_prec (req_out_prec),
    .q_data_in    (q_data_in),
    .q_in_prec    (q_in_prec),
    .q_out_prec   (q_out_prec),
    .q_data_out   (q_data_out),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  function automatic logic [31:0] qmodel(input logic [31:0] d, input logic [15:0] op);
    case (op)
      16'h0002: return d & 32'h0000_FFFF;
      16'h0004: return d & 32'h0000_00FF;
      default:  return d;
    endcase
  endfunction

  always @(posedge clk) q_data_out <= qmodel(q_data_in, q_out_prec);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_payload(input int idx, input logic [31:0] d,
                             input logic [15:0] ip, input logic [15:0] op);
    req_data[32*idx +: 32]     = d;
    req_in_prec[16*idx +: 16]  = ip;
    req_out_prec[16*idx +: 16] = op;
  endtask

  // Called just after a negedge; returns #1 after the negedge preceding the accept edge.
  task automatic wait_ready(input int idx);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'(req_ready[idx]), 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [15:0] ip;
    logic [15:0] op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic run_one(input vec_t v);
    @(negedge clk);
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    set_payload(v.idx, v.data, v.ip, v.op);
    resp_ready = 1'b1;
    wait_ready(v.idx);
    @(negedge clk);               // after accept edge: ISSUE
    req_valid = '0;
    #1;
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_q_data", q_data_in, v.data);
    chk("issue_q_in_prec", 32'(q_in_prec), 32'(v.ip));
    @(negedge clk);               // CAPT
    chk("capt_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);               // RESP: third edge counting the accept edge
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(v.idx));
    chk("resp_data", resp_data, v.exp_data);
    chk("resp_err", 32'(resp_err), 32'(v.exp_err));
    $display("txn id=%0d data=%h in=%h out=%h -> resp_data=%h err=%0d",
             v.idx, v.data, v.ip, v.op, resp_data, resp_err);
    @(negedge clk);               // back to IDLE
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  int acc_idx [5];
  int acc_cyc [5];
  int n_acc;

  initial begin
    vecs[0] = '{0, 32'h1234_5678, 16'h0001, 16'h0001, 32'h1234_5678, 1'b0};
    vecs[1] = '{1, 32'hAABB_CCDD, 16'h0001, 16'h0002, 32'h0000_CCDD, 1'b0};
    vecs[2] = '{2, 32'hAABB_CCDD, 16'h0002, 16'h0004, 32'h0000_00DD, 1'b0};
    vecs[3] = '{3, 32'h0000_1234, 16'h0003, 16'h0001, 32'h0000_0000, 1'b1};
    vecs[4] = '{0, 32'h0000_0005, 16'h0001, 16'h0008, 32'h0000_0000, 1'b1};
    vecs[5] = '{1, 32'hDEAD_BEEF, 16'h0004, 16'h0001, 32'hDEAD_BEEF, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_q_data", q_data_in, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_one(vecs[i]);

    // Round-robin with all requesters held valid, starting from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_payload(i, 32'h100 + i, 16'h0001, 16'h0001);
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if ($countones(req_ready) > 1) chk("rr_onehot", 32'(req_ready), 32'd0);
      if (|req_ready) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) acc_idx[n_acc] = k;
        acc_cyc[n_acc] = c;
        $display("txn rr accept %0d -> requester %0d at cycle %0d", n_acc, acc_idx[n_acc], c);
        n_acc++;
        if (n_acc == 5) break;
      end
      @(negedge clk);
    end
    chk("rr_accept_count", 32'(n_acc), 32'd5);
    for (int i = 0; i < n_acc; i++) chk("rr_order", 32'(acc_idx[i]), 32'(i % N));
    for (int i = 1; i < n_acc; i++) chk("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Response back-pressure while another requester waits
    req_valid = 4'b0100;
    set_payload(2, 32'hCAFE_F00D, 16'h0001, 16'h0002);
    resp_ready = 1'b0;
    wait_ready(2);
    @(negedge clk);
    req_valid = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (resp_valid) break;
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_data", resp_data, 32'h0000_F00D);
      chk("bp_resp_id", 32'(resp_id), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    $display("txn bp id=%0d resp_data=%h released", resp_id, resp_data);
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_resp_valid", 32'(resp_valid), 32'd0);

    // Reset in the middle of CAPT
    req_valid = 4'b0010;
    set_payload(1, 32'h5555_AAAA, 16'h0001, 16'h0001);
    wait_ready(1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("capt_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_q_data", q_data_in, 32'd0);
    chk("mid_rst_q_out_prec", 32'(q_out_prec), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    req_valid = 4'hF;
    #1;
    chk("post_rst_first_grant", 32'(req_ready), 32'd1);
    $display("txn post-reset grant=%b", req_ready);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
